trace_plotter: RTL and testbench
================================

# trace_plotter

Receiving end of the waveform-drawing path. It accepts one (column, row, colour) sample per handshake from a trace generator, such as the sine sweep that emits column 0..159 plus a ROM row. It erases the pixel previously plotted in that column, then writes the new pixel through the framebuffer write port of the 160x120 VGA adapter. Per-column history makes successive sweeps overwrite cleanly, with no full-screen clear.

## Interface
- `BG_COLOR`, default 12'h000: colour written when erasing an old trace pixel.
- `X_MAX`, default 159: last valid column; a sample with x == X_MAX ends a sweep.
- `Y_MAX`, default 119: last valid row; larger y values are clamped.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `in_x`  in  8  sample column.
- `in_y`  in  8  sample row.
- `in_color`  in  12  sample colour (RGB 4:4:4).
- `in_valid`  in  1  sample present.
- `in_ready`  out  1  plotter can accept a sample this cycle.
- `clear`  in  1  one-cycle pulse that forgets all column history; pixels are not erased.
- `fb_x`  out  8  framebuffer write column.
- `fb_y`  out  7  framebuffer write row.
- `fb_color`  out  12  framebuffer write colour.
- `fb_we`  out  1  framebuffer write strobe, one pixel per cycle while high.
- `sweep_done`  out  1  one-cycle pulse after the pixel for column X_MAX is written.
- `drop`  out  1  one-cycle pulse when an accepted sample has x > X_MAX.

## Operation
- Internal history: 160 entries, each holding 7-bit `hist_y` and 1-bit `hist_v`. Reset clears all `hist_v`; `hist_y` contents are don't-care.
- FSM states are IDLE, ERASE and DRAW. `in_ready` = (state == IDLE).
- **Accept.** A sample is accepted when `in_valid` and `in_ready` are both high. The plotter latches x, y_clamped and colour.
  - y_clamped = min(in_y, Y_MAX), truncated to 7 bits after clamping.
- **IDLE transitions after accept:**
  - x > X_MAX: pulse `drop` next cycle, stay in IDLE. No write, no history change.
  - `hist_v[x]` = 1: go to ERASE.
  - Otherwise: go to DRAW.
- **ERASE (1 cycle):** `fb_we`=1, `fb_x`=x, `fb_y`=`hist_y[x]`, `fb_color`=BG_COLOR. Next state is DRAW.
- **DRAW (1 cycle):** `fb_we`=1, `fb_x`=x, `fb_y`=y_clamped, `fb_color`=latched colour.
  - On exit: `hist_y[x]` <= y_clamped, `hist_v[x]` <= 1.
  - Next state is IDLE.
  - If x == X_MAX, `sweep_done` is high for the cycle after DRAW.
- **Same-row repeat:** if the old row equals the new row, ERASE still runs. The net framebuffer result is the new colour.
- **clear:** sampled every cycle. It zeroes all `hist_v` at the next edge.
  - Simultaneous with the DRAW-exit update: the DRAW column stays valid; all others clear.
  - Simultaneous with an accept in IDLE: the ERASE/DRAW decision uses the pre-clear `hist_v`.
- **Outputs:** `fb_*`, `sweep_done` and `drop` are driven from registers only, with no combinational path from inputs. `fb_x`, `fb_y` and `fb_color` hold their last values while `fb_we`=0.
- **Reset mid-operation:** abort immediately to IDLE and clear history. No further write is issued.

## Timing
- **Reset values:** state IDLE, `in_ready`=1, `fb_we`=0, `fb_x`=0, `fb_y`=0, `fb_color`=0, `sweep_done`=0, `drop`=0, all `hist_v`=0.
- Accept at edge N. If history is valid: ERASE write during cycle N+1, DRAW write during N+2, `in_ready` high again in N+3.
- Accept at edge N with no history: DRAW during N+1, `in_ready` high in N+2.
- Throughput: one sample per 2 cycles (fresh column) or per 3 cycles (overwrite).
- `sweep_done` is asserted in the same cycle `in_ready` returns high.
- `in_valid` held high with changing data is legal. Only data present on accept edges is used.

## Test plan
- **Reset, then fresh sample.** Stimulus: sample (x=5, y=40, colour F00). Required: one write (5, 40, F00) in cycle N+1, `in_ready` low for 1 cycle, no ERASE.
- **Overwrite a column.** Stimulus: (5, 40, F00) then (5, 70, 0F0). Required: write (5, 40, 000), then (5, 70, 0F0) on consecutive cycles; `hist_y[5]`=70.
- **Full sweep.** Stimulus: x=0..159 with `in_valid` held high. Required: 160 DRAW writes, no ERASE, `sweep_done` pulses exactly once after x=159. On a second sweep each column gives ERASE then DRAW, with 3-cycle spacing.
- **Clamp and drop.** Stimulus: (10, 200, FFF). Required: write row 119. Stimulus: (160, 3, FFF). Required: `drop` pulse, `fb_we` stays 0.
- **clear collision.** Stimulus: `clear` asserted on the DRAW-exit edge of x=7, after x=3 was already plotted. Required: the next sample at x=7 is erased; the next sample at x=3 skips ERASE.
- **Reset in ERASE.** Stimulus: assert `reset` during ERASE. Required: `fb_we` drops immediately, no DRAW write, `in_ready`=1 after release, history empty.

Source files
------------

// File: rtl/trace_plotter_if.sv
// rtl/trace_plotter_if.sv - sample stream and framebuffer write port bundle for trace_plotter
interface trace_plotter_if;
  logic [7:0]  in_x;
  logic [7:0]  in_y;
  logic [11:0] in_color;
  logic        in_valid;
  logic        in_ready;
  logic        clear;
  logic [7:0]  fb_x;
  logic [6:0]  fb_y;
  logic [11:0] fb_color;
  logic        fb_we;
  logic        sweep_done;
  logic        drop;

  // Trace generator side: produces samples, observes the framebuffer port
  modport master (
    output in_x, in_y, in_color, in_valid, clear,
    input  in_ready, fb_x, fb_y, fb_color, fb_we, sweep_done, drop
  );

  // Plotter side: consumes samples, drives the framebuffer port
  modport slave (
    input  in_x, in_y, in_color, in_valid, clear,
    output in_ready, fb_x, fb_y, fb_color, fb_we, sweep_done, drop
  );
endinterface

// File: rtl/trace_plotter.sv
// rtl/trace_plotter.sv - per-column erase-then-draw plotter into a 160x120 framebuffer
module trace_plotter #(
  parameter logic [11:0] BG_COLOR = 12'h000,
  parameter int          X_MAX    = 159,
  parameter int          Y_MAX    = 119
) (
  input  logic          clk,
  input  logic          reset,
  trace_plotter_if.slave bus
);

  localparam int         HIST_N = X_MAX + 1;
  localparam logic [7:0] XMAX8  = 8'(X_MAX);
  localparam logic [7:0] YMAX8  = 8'(Y_MAX);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW} state_t;

  state_t             state_q, state_d;
  logic [7:0]         x_q, x_d;
  logic [6:0]         y_q, y_d;
  logic [11:0]        color_q, color_d;
  logic [7:0]         fb_x_q, fb_x_d;
  logic [6:0]         fb_y_q, fb_y_d;
  logic [11:0]        fb_color_q, fb_color_d;
  logic               fb_we_q, fb_we_d;
  logic               sweep_done_q, sweep_done_d;
  logic               drop_q, drop_d;
  logic [HIST_N-1:0]  hist_v_q, hist_v_d;
  logic [6:0]         hist_y_q [HIST_N];
  logic               hist_we;

  logic               accept;
  logic               in_range;
  logic               hist_hit;
  logic [6:0]         y_clamped;

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.fb_x       = fb_x_q;
  assign bus.fb_y       = fb_y_q;
  assign bus.fb_color   = fb_color_q;
  assign bus.fb_we      = fb_we_q;
  assign bus.sweep_done = sweep_done_q;
  assign bus.drop       = drop_q;

  assign accept    = bus.in_valid && (state_q == IDLE);
  assign in_range  = (bus.in_x <= XMAX8);
  // Decision uses the history as it stood before any same-cycle clear
  assign hist_hit  = in_range && hist_v_q[bus.in_x];
  assign y_clamped = (bus.in_y > YMAX8) ? YMAX8[6:0] : bus.in_y[6:0];

  // Next state, next registered outputs and history-valid update
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    color_d      = color_q;
    fb_x_d       = fb_x_q;
    fb_y_d       = fb_y_q;
    fb_color_d   = fb_color_q;
    fb_we_d      = 1'b0;
    sweep_done_d = 1'b0;
    drop_d       = 1'b0;
    hist_we      = 1'b0;
    hist_v_d     = bus.clear ? '0 : hist_v_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          x_d     = bus.in_x;
          y_d     = y_clamped;
          color_d = bus.in_color;
          if (!in_range) begin
            drop_d = 1'b1;
          end else begin
            fb_we_d = 1'b1;
            fb_x_d  = bus.in_x;
            if (hist_hit) begin
              state_d    = ERASE;
              fb_y_d     = hist_y_q[bus.in_x];
              fb_color_d = BG_COLOR;
            end else begin
              state_d    = DRAW;
              fb_y_d     = y_clamped;
              fb_color_d = bus.in_color;
            end
          end
        end
      end
      ERASE: begin
        state_d    = DRAW;
        fb_we_d    = 1'b1;
        fb_y_d     = y_q;
        fb_color_d = color_q;
      end
      DRAW: begin
        state_d        = IDLE;
        hist_we        = 1'b1;
        // Set after the clear so the column just drawn survives a colliding clear
        hist_v_d[x_q]  = 1'b1;
        sweep_done_d   = (x_q == XMAX8);
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched sample, output registers and history-valid bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      color_q      <= '0;
      fb_x_q       <= '0;
      fb_y_q       <= '0;
      fb_color_q   <= '0;
      fb_we_q      <= 1'b0;
      sweep_done_q <= 1'b0;
      drop_q       <= 1'b0;
      hist_v_q     <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      color_q      <= color_d;
      fb_x_q       <= fb_x_d;
      fb_y_q       <= fb_y_d;
      fb_color_q   <= fb_color_d;
      fb_we_q      <= fb_we_d;
      sweep_done_q <= sweep_done_d;
      drop_q       <= drop_d;
      hist_v_q     <= hist_v_d;
    end
  end

  // Row history is plain storage; its validity lives in hist_v_q
  always_ff @(posedge clk) begin
    if (hist_we) begin
      hist_y_q[x_q] <= y_q;
    end
  end

endmodule

// File: tb/tb_trace_plotter.sv
// tb/tb_trace_plotter.sv - directed self-checking bench for trace_plotter
module tb_trace_plotter;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  trace_plotter_if bus ();

  trace_plotter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [11:0] c);
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_color = c;
    bus.in_valid = 1'b1;
  endtask

  task automatic check_write(input string tag, input logic [7:0] x, input logic [6:0] y,
                             input logic [11:0] c);
    check({tag, "_we"}, bus.fb_we, 1);
    check({tag, "_x"}, bus.fb_x, x);
    check({tag, "_y"}, bus.fb_y, y);
    check({tag, "_color"}, bus.fb_color, c);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b1;
    bus.in_x     = '0;
    bus.in_y     = '0;
    bus.in_color = '0;
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_ready", bus.in_ready, 1);
    check("rst_we", bus.fb_we, 0);
    check("rst_x", bus.fb_x, 0);
    check("rst_y", bus.fb_y, 0);
    check("rst_color", bus.fb_color, 0);
    check("rst_done", bus.sweep_done, 0);
    check("rst_drop", bus.drop, 0);

    // Fresh sample: single DRAW in N+1
    send(8'd5, 8'd40, 12'hF00);
    tick();
    check_write("fresh", 8'd5, 7'd40, 12'hF00);
    check("fresh_busy", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    tick();
    check("fresh_we_off", bus.fb_we, 0);
    check("fresh_ready", bus.in_ready, 1);
    check("fresh_done", bus.sweep_done, 0);

    // Overwrite column 5: ERASE row 40 then DRAW row 70
    send(8'd5, 8'd70, 12'h0F0);
    tick();
    check_write("ovw_erase", 8'd5, 7'd40, 12'h000);
    check("ovw_busy", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    tick();
    check_write("ovw_draw", 8'd5, 7'd70, 12'h0F0);
    tick();
    check("ovw_we_off", bus.fb_we, 0);
    check("ovw_ready", bus.in_ready, 1);

    // Same-row repeat: history of column 5 is 70, ERASE still runs
    send(8'd5, 8'd70, 12'h00F);
    tick();
    check_write("same_erase", 8'd5, 7'd70, 12'h000);
    bus.in_valid = 1'b0;
    tick();
    check_write("same_draw", 8'd5, 7'd70, 12'h00F);
    tick();

    // Clamp: row 200 becomes 119
    send(8'd10, 8'd200, 12'hFFF);
    tick();
    check_write("clamp", 8'd10, 7'd119, 12'hFFF);
    bus.in_valid = 1'b0;
    tick();

    // Drop: x=160 out of range, no write, outputs hold
    send(8'd160, 8'd3, 12'hFFF);
    tick();
    check("drop_pulse", bus.drop, 1);
    check("drop_we", bus.fb_we, 0);
    check("drop_ready", bus.in_ready, 1);
    check("drop_hold_x", bus.fb_x, 10);
    check("drop_hold_y", bus.fb_y, 119);
    bus.in_valid = 1'b0;
    tick();
    check("drop_end", bus.drop, 0);

    // clear collision: plot x=3, then clear on DRAW-exit edge of x=7
    send(8'd3, 8'd20, 12'h0AA);
    tick();
    check_write("col_x3", 8'd3, 7'd20, 12'h0AA);
    bus.in_valid = 1'b0;
    tick();
    send(8'd7, 8'd50, 12'h0BB);
    tick();
    check_write("col_x7", 8'd7, 7'd50, 12'h0BB);
    bus.in_valid = 1'b0;
    bus.clear    = 1'b1;
    tick();
    bus.clear    = 1'b0;
    send(8'd7, 8'd60, 12'h0CC);
    tick();
    check_write("col_x7_erase", 8'd7, 7'd50, 12'h000);
    bus.in_valid = 1'b0;
    tick();
    check_write("col_x7_draw", 8'd7, 7'd60, 12'h0CC);
    tick();
    send(8'd3, 8'd25, 12'h0DD);
    tick();
    check_write("col_x3_fresh", 8'd3, 7'd25, 12'h0DD);
    bus.in_valid = 1'b0;
    tick();
    check("col_x3_ready", bus.in_ready, 1);

    // Forget all history before the sweeps
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;

    // First sweep: DRAW only, in_valid held high
    send(8'd0, 8'd0, 12'h100);
    for (int x = 0; x < 160; x++) begin
      tick();
      check_write("sw1_draw", 8'(x), 7'(x / 2), 12'h100 + 12'(x));
      check("sw1_busy", bus.in_ready, 0);
      if (x < 159) send(8'(x + 1), 8'((x + 1) / 2), 12'h100 + 12'(x + 1));
      else bus.in_valid = 1'b0;
      tick();
      check("sw1_ready", bus.in_ready, 1);
      check("sw1_done", bus.sweep_done, (x == 159) ? 1 : 0);
    end
    tick();
    check("sw1_done_once", bus.sweep_done, 0);

    // Second sweep: ERASE then DRAW per column, 3-cycle spacing
    send(8'd0, 8'd1, 12'h200);
    for (int x = 0; x < 160; x++) begin
      tick();
      check_write("sw2_erase", 8'(x), 7'(x / 2), 12'h000);
      if (x < 159) send(8'(x + 1), 8'((x + 1) / 2 + 1), 12'h200 + 12'(x + 1));
      else bus.in_valid = 1'b0;
      tick();
      check_write("sw2_draw", 8'(x), 7'(x / 2 + 1), 12'h200 + 12'(x));
      check("sw2_busy", bus.in_ready, 0);
      tick();
      check("sw2_ready", bus.in_ready, 1);
      check("sw2_done", bus.sweep_done, (x == 159) ? 1 : 0);
    end

    // Reset during ERASE of column 0 (history row 1)
    send(8'd0, 8'd5, 12'h0EE);
    tick();
    check_write("rerase", 8'd0, 7'd1, 12'h000);
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    #1;
    check("rerase_we_drop", bus.fb_we, 0);
    check("rerase_ready", bus.in_ready, 1);
    tick();
    reset = 1'b0;
    tick();
    check("rerase_no_draw", bus.fb_we, 0);
    check("rerase_ready2", bus.in_ready, 1);
    send(8'd0, 8'd9, 12'hABC);
    tick();
    check_write("rerase_fresh", 8'd0, 7'd9, 12'hABC);
    bus.in_valid = 1'b0;
    tick();
    check("rerase_end_ready", bus.in_ready, 1);
    check("rerase_end_we", bus.fb_we, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
